// File: rtl/led_pattern_pkg.sv
// Shared encodings and seed helper for the reconfigurable LED pattern engine.
package led_pattern_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_UP     = 3'd0;
  localparam mode_t MODE_DOWN   = 3'd1;
  localparam mode_t MODE_ROTL   = 3'd2;
  localparam mode_t MODE_ROTR   = 3'd3;
  localparam mode_t MODE_BOUNCE = 3'd4;
  localparam mode_t MODE_HOLD   = 3'd5;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int LED_W_MAX = 16;

  // Pattern loaded on a mode switch; HOLD (and 6,7) keep the current pattern.
  function automatic logic [LED_W_MAX-1:0] seed(input mode_t mode, input int led_w,
                                                input logic [LED_W_MAX-1:0] cur);
    logic [LED_W_MAX-1:0] ones;
    ones = (LED_W_MAX'(1) << led_w) - LED_W_MAX'(1);
    case (mode)
      MODE_UP:                 return '0;
      MODE_DOWN:               return ones;
      MODE_ROTL, MODE_BOUNCE:  return LED_W_MAX'(1);
      MODE_ROTR:               return LED_W_MAX'(1) << (led_w - 1);
      default:                 return cur;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control and LED-side signals of the pattern engine.
interface led_pattern_gen_if #(parameter int LED_W = 4);
  import led_pattern_pkg::*;

  logic             en;
  mode_t            mode;
  logic             load;
  logic [LED_W-1:0] load_val;
  logic [LED_W-1:0] led_out;
  logic             dir_out;
  logic             tick_out;

  modport master (output en, mode, load, load_val, input led_out, dir_out, tick_out);
  modport slave  (input en, mode, load, load_val, output led_out, dir_out, tick_out);
endinterface

// File: rtl/led_prescaler.sv
// Wrapping 0..PRESCALE_MAX counter with synchronous clear; tick on the terminal count.
module led_prescaler #(
  parameter  int PRESCALE_MAX = 33554431,
  localparam int PS_W         = $clog2(PRESCALE_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [PS_W-1:0] cnt;

  assign tick = en && (cnt == PS_W'(PRESCALE_MAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (tick)   cnt <= '0;
    else if (en)     cnt <= cnt + PS_W'(1);
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: each prescaler tick either switches mode (seeding the
// pattern) or advances the current pattern; a load overrides both.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_W        = 4,
  parameter int PRESCALE_MAX = 33554431
) (
  input logic               clk,
  input logic               rst,
  led_pattern_gen_if.slave  bus
);

  logic             tick;
  logic             tick_q;
  logic             dir_q;
  logic             nxt_dir;
  mode_t            mode_q;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] nxt_led;

  led_prescaler #(.PRESCALE_MAX(PRESCALE_MAX)) u_ps (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick)
  );

  // Pattern value for a tick cycle; only committed when tick && !load.
  always_comb begin
    nxt_led = led_q;
    nxt_dir = dir_q;
    if (bus.mode != mode_q) begin
      nxt_led = LED_W'(seed(bus.mode, LED_W, LED_W_MAX'(led_q)));
      if (bus.mode == MODE_BOUNCE) nxt_dir = DIR_UP;
    end else begin
      case (mode_q)
        MODE_UP:   nxt_led = led_q + LED_W'(1);
        MODE_DOWN: nxt_led = led_q - LED_W'(1);
        MODE_ROTL: nxt_led = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_ROTR: nxt_led = {led_q[0], led_q[LED_W-1:1]};
        MODE_BOUNCE: begin
          // Reversal happens on the tick that sees the end LED lit, so each
          // end is shown for exactly one tick per sweep.
          if (dir_q == DIR_UP) begin
            if (led_q[LED_W-1]) begin
              nxt_dir = DIR_DOWN;
              nxt_led = led_q >> 1;
            end else begin
              nxt_led = led_q << 1;
            end
          end else begin
            if (led_q[0]) begin
              nxt_dir = DIR_UP;
              nxt_led = led_q << 1;
            end else begin
              nxt_led = led_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q  <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      mode_q <= MODE_UP;
    end else begin
      tick_q <= tick && !bus.load;
      if (bus.load) begin
        led_q <= bus.load_val;
      end else if (tick) begin
        led_q  <= nxt_led;
        dir_q  <= nxt_dir;
        mode_q <= bus.mode;
      end
    end
  end

  assign bus.led_out  = led_q;
  assign bus.dir_out  = dir_q;
  assign bus.tick_out = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed plan checks plus randomized run against an arithmetic reference model.
module tb_led_pattern_gen;

  localparam int LED_W = 4;
  localparam int PM    = 3;
  localparam int N     = 1 << LED_W;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  led_pattern_gen_if #(.LED_W(LED_W)) bus ();

  led_pattern_gen #(.LED_W(LED_W), .PRESCALE_MAX(PM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: prescaler count, pattern as an integer, direction, mode.
  int m_ps = 0, m_led = 0, m_dir = 0, m_mode = 0, m_tick = 0;
  bit t;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ps = 0; m_led = 0; m_dir = 0; m_mode = 0; m_tick = 0;
    end else begin
      t = bus.en && (m_ps == PM);
      if (bus.load) begin
        m_led = int'(bus.load_val); m_ps = 0; m_tick = 0;
      end else if (t) begin
        m_tick = 1; m_ps = 0;
        if (int'(bus.mode) != m_mode) begin
          m_mode = int'(bus.mode);
          case (m_mode)
            0:       m_led = 0;
            1:       m_led = N - 1;
            2, 4:    m_led = 1;
            3:       m_led = N / 2;
            default: ;
          endcase
          if (m_mode == 4) m_dir = 0;
        end else begin
          case (m_mode)
            0: m_led = (m_led + 1) % N;
            1: m_led = (m_led + N - 1) % N;
            2: m_led = (m_led * 2) % N + m_led / (N / 2);
            3: m_led = m_led / 2 + (m_led % 2) * (N / 2);
            4: begin
              if (m_dir == 0) begin
                if (m_led >= N / 2) begin m_dir = 1; m_led = m_led / 2; end
                else m_led = (m_led * 2) % N;
              end else begin
                if (m_led % 2 == 1) begin m_dir = 0; m_led = (m_led * 2) % N; end
                else m_led = m_led / 2;
              end
            end
            default: ;
          endcase
        end
      end else begin
        m_tick = 0;
        if (bus.en) m_ps = m_ps + 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_led",  int'(bus.led_out),  m_led);
    chk("cmp_dir",  int'(bus.dir_out),  m_dir);
    chk("cmp_tick", int'(bus.tick_out), m_tick);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int md);
    rst = 1'b0;
    bus.mode = 3'(md);
    step(2);
    rst = 1'b1;
  endtask

  int exp_b_led[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
  int exp_b_dir[8] = '{0, 0, 0, 0, 1, 1, 1, 0};

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.mode = 3'd0; bus.load = 1'b0; bus.load_val = '0;
    step(3);
    chk("rst_led",  int'(bus.led_out), 0);
    chk("rst_dir",  int'(bus.dir_out), 0);
    chk("rst_tick", int'(bus.tick_out), 0);

    // UP count, wraps after 16 ticks
    bus.en = 1'b1; rst = 1'b1;
    step(4);
    chk("t1_first_tick", int'(bus.tick_out), 1);
    chk("t1_first_led",  int'(bus.led_out), 1);
    chk("t1_model",      m_led, 1);
    for (int i = 2; i <= 17; i++) begin
      step(4);
      chk("t1_count", int'(bus.led_out), i % 16);
      chk("t1_tick",  int'(bus.tick_out), 1);
    end

    // DOWN: seed then decrement with wrap
    do_reset(1);
    step(4);
    chk("t2_seed", int'(bus.led_out), 15);
    for (int i = 1; i <= 17; i++) begin
      step(4);
      chk("t2_count", int'(bus.led_out), (15 - i + 32) % 16);
    end

    // BOUNCE sweep
    do_reset(4);
    for (int k = 0; k < 8; k++) begin
      step(4);
      chk("t3_led", int'(bus.led_out), exp_b_led[k]);
      chk("t3_dir", int'(bus.dir_out), exp_b_dir[k]);
    end

    // Load during ROTL on the terminal prescaler cycle
    do_reset(2);
    step(4);
    chk("t4_seed", int'(bus.led_out), 1);
    step(4);
    chk("t4_rot", int'(bus.led_out), 2);
    step(3);
    bus.load = 1'b1; bus.load_val = 4'b1010;
    step(1);
    bus.load = 1'b0;
    chk("t4_load_led",  int'(bus.led_out), 10);
    chk("t4_load_tick", int'(bus.tick_out), 0);
    step(4);
    chk("t4_after_led",  int'(bus.led_out), 5);
    chk("t4_after_tick", int'(bus.tick_out), 1);

    // Freeze at prescaler=2, resume two cycles to tick
    step(2);
    bus.en = 1'b0;
    step(10);
    chk("t5_frozen_led",  int'(bus.led_out), 5);
    chk("t5_frozen_tick", int'(bus.tick_out), 0);
    bus.en = 1'b1;
    step(1);
    chk("t5_resume1_tick", int'(bus.tick_out), 0);
    step(1);
    chk("t5_resume2_tick", int'(bus.tick_out), 1);
    chk("t5_resume2_led",  int'(bus.led_out), 10);

    // Async reset mid-BOUNCE while sweeping down
    do_reset(4);
    repeat (5) step(4);
    chk("t6_dir_before", int'(bus.dir_out), 1);
    step(2);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_led",  int'(bus.led_out), 0);
    chk("t6_async_dir",  int'(bus.dir_out), 0);
    chk("t6_async_tick", int'(bus.tick_out), 0);
    step(1);
    rst = 1'b1;
    step(4);
    chk("t6_seed_led",  int'(bus.led_out), 1);
    chk("t6_seed_tick", int'(bus.tick_out), 1);
    chk("t6_seed_dir",  int'(bus.dir_out), 0);

    // Randomized run; the per-cycle compare process checks against the model
    for (int c = 0; c < 1500; c++) begin
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) bus.mode = 3'($urandom_range(0, 7));
      bus.load = ($urandom_range(0, 24) == 0);
      bus.load_val = LED_W'($urandom_range(0, N - 1));
      rst = ($urandom_range(0, 199) != 0);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the reconfigurable LED region. It is the next-generation replacement for the fixed 4-bit binary up-counter. A runtime-programmable prescaler produces a slow tick, and each tick advances an LED_W-wide pattern in one of several modes: count up, count down, rotate left, rotate right, ping-pong bounce, or hold. Synchronous load and enable controls are provided for static-logic and PR test control.

Parameters:
LED_W, 4, number of LED outputs; legal range 2..16.
PRESCALE_MAX, 33554431, terminal prescaler value; tick period is PRESCALE_MAX+1 clk cycles. Must be >= 1.
PS_W, $clog2(PRESCALE_MAX+1), prescaler counter width (derived; not overridden).

Ports:
clk  in  1  200 MHz clock
rst  in  1  asynchronous active-low reset
en  in  1  1 = prescaler runs and pattern advances; 0 = freeze everything
mode  in  3  pattern mode request: 0 UP, 1 DOWN, 2 ROTL, 3 ROTR, 4 BOUNCE, 5-7 HOLD
load  in  1  synchronous load strobe
load_val  in  LED_W  value for a load
led_out  out  LED_W  registered pattern to LEDs
dir_out  out  1  BOUNCE direction: 0 = toward MSB, 1 = toward LSB
tick_out  out  1  one-cycle pulse, registered, asserted in the same cycle led_out shows the updated value

Behaviour:
- Reset (rst=0, async): prescaler=0, led_out=0, dir_out=0, tick_out=0, mode_q=UP.
- Prescaler:
  - When en=1, counts 0..PRESCALE_MAX and wraps to 0.
  - Internal tick = en && prescaler==PRESCALE_MAX.
  - When en=0, the prescaler holds its value.
- tick_out is the registered internal tick, so it rises together with the led_out update.
- Priority each cycle: load > tick > hold.
- Load:
  - led_out<=load_val and prescaler<=0, regardless of en.
  - mode_q and dir_out are unchanged; tick_out=0 that cycle.
  - A tick coinciding with load is discarded.
- Tick with mode != mode_q (mode switch):
  - mode_q<=mode.
  - led_out<=seed of the new mode: UP 0; DOWN all-ones; ROTL 1; ROTR 1<<(LED_W-1); BOUNCE 1 with dir_out<=0; HOLD keeps the current value.
  - No advance occurs on this tick.
- Tick with mode == mode_q (advance):
  - UP: led_out+1, modulo 2^LED_W (all-ones wraps to 0).
  - DOWN: led_out-1, modulo 2^LED_W (0 wraps to all-ones).
  - ROTL: rotate left by 1, MSB to LSB. ROTR: rotate right by 1, LSB to MSB. An all-zero pattern stays all-zero; no auto-reseed except through a mode switch.
  - BOUNCE, dir=0:
    - If led_out[LED_W-1]=1: dir_out<=1 and led_out>>1.
    - Else: led_out<<1.
  - BOUNCE, dir=1:
    - If led_out[0]=1: dir_out<=0 and led_out<<1.
    - Else: led_out>>1.
    - End LEDs are lit for exactly one tick per sweep.
  - BOUNCE with non-one-hot content (e.g. after a load): apply the same shift rules; bits shifted out are lost.
  - HOLD: no change.
- Mode changes between ticks are ignored until the next tick; mode is sampled only on tick cycles.
- en deasserted mid-period: the prescaler keeps its count, and on re-enable the period resumes from that count.
- Reset asserted mid-operation returns all state to the reset values immediately; the first tick after release occurs PRESCALE_MAX+1 cycles later with en=1.

Decomposition:
- Package led_pattern_pkg:
  - mode encodings: MODE_UP, MODE_DOWN, MODE_ROTL, MODE_ROTR, MODE_BOUNCE, MODE_HOLD
  - DIR_UP=0, DIR_DOWN=1
  - a seed function (mode, LED_W) returning the seed value
- Sub-module led_prescaler (parameter PRESCALE_MAX; ports clk, rst, en, clr, tick): a free-running counter with synchronous clear and tick output, reusable across other LED reconfigurable modules.

Test Plan:
Common setup: LED_W=4, PRESCALE_MAX=3.
1. Reset, then en=1, mode=0 for 80 cycles -> tick_out pulses every 4 cycles; led_out 0,1,2,...,15,0 (wraps after 16 ticks).
2. mode=1 held from reset -> first tick seeds 4'b1111 (mode switch); subsequent ticks 1110, 1101, ...; after 0000 the next tick gives 1111.
3. mode=4 -> ticks give seed 0001, then 0010, 0100, 1000, 0100 (dir_out rises on that tick), 0010, 0001, 0010 (dir_out falls).
4. During mode=2 rotating, load=1 with load_val=4'b1010 on the cycle the prescaler is at 3 -> led_out=1010, tick_out=0, prescaler restarts; next tick (4 cycles later) gives 0101.
5. en=0 for 10 cycles at prescaler=2 -> led_out and tick_out frozen; after en=1, the tick occurs exactly 2 cycles later.
6. Assert rst mid-BOUNCE with dir_out=1 -> led_out=0, dir_out=0, tick_out=0 asynchronously; after release with mode=4, the first tick seeds 0001.
